// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// Oversampled asynchronous serial receiver feeding a first-word-fall-through FIFO.
// A frame is one start bit, DATA_WIDTH data bits (LSB first), an optional
// parity bit and STOP_BITS stop bits. Each bit is the 3-sample majority around
// mid-bit. Frames with parity or stop-bit errors are reported and never stored.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   data       FIFO head word (0 while the FIFO is empty)
//   valid      FIFO non-empty
//   ready      consumer pops the head when valid && ready
//   count      FIFO occupancy, 0..FIFO_DEPTH
//   busy       receiver is inside a frame (or waiting out a break)
//   parity_err one-cycle pulse, bad parity on a finished frame
//   frame_err  one-cycle pulse, a stop bit sampled low
//   overrun    one-cycle pulse, good frame dropped because the FIFO was full
//   timeout    idle-with-data indication
//
// Optional feature macro: UART_RX_TIMEOUT_EN. When it is undefined no idle
// counter is built and timeout is tied low.
`timescale 1ns/1ps

module uart_rx_buffered #(
    parameter int CLOCK_RATE    = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          timeout
);

    localparam int SAMPLE_RATE = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_ROUND   = (CLOCK_RATE + SAMPLE_RATE / 2) / SAMPLE_RATE;
    localparam int DIV         = (DIV_ROUND < 1) ? 1 : DIV_ROUND;
    localparam int DIVW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW          = $clog2(OVERSAMPLE);
    localparam int BW          = $clog2(DATA_WIDTH);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CW          = AW + 1;

    if (CLOCK_RATE < SAMPLE_RATE) begin : gRateCheck
        $error("uart_rx_buffered: CLOCK_RATE is below BAUD_RATE*OVERSAMPLE");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   rxMeta_q, rxSync_q, rxPrev_q;
    logic [DIVW-1:0]        divCnt_q;
    logic [TW-1:0]          tickCnt_q;
    logic [BW-1:0]          bitCnt_q;
    logic                   stopCnt_q;
    logic                   smp0_q, smp1_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   parBit_q, stopLow_q, stopHigh_q;
    logic                   parityErr_q, frameErr_q, overrun_q;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wrPtr_q, rdPtr_q;
    logic [CW-1:0]          count_q;

    logic fall, startEdge, tick, midTick, bitEnd, majority, lastStop, commit;
    logic expectedPar, parBad, frmBad, isBreak, good, pop, full, wrEn;

    // Tick strobes and per-bit sample points; the third sample is the live
    // synchronised value so the majority is ready on the last sample tick.
    always_comb begin
        fall        = rxPrev_q & ~rxSync_q;
        startEdge   = (state_q == ST_IDLE) && fall;
        tick        = (divCnt_q == DIVW'(DIV - 1));
        midTick     = tick && (tickCnt_q == TW'(OVERSAMPLE / 2 + 1));
        bitEnd      = tick && (tickCnt_q == TW'(OVERSAMPLE - 1));
        majority    = (smp0_q & smp1_q) | (smp0_q & rxSync_q) | (smp1_q & rxSync_q);
        lastStop    = (stopCnt_q == 1'(STOP_BITS - 1));
        commit      = (state_q == ST_STOP) && midTick && lastStop;
        expectedPar = (PARITY == 1) ? ~^shift_q : ^shift_q;
        parBad      = (PARITY != 0) && (parBit_q != expectedPar);
        frmBad      = stopLow_q | ~majority;
        isBreak     = (shift_q == '0) && !stopHigh_q && !majority;
        good        = !parBad && !frmBad;
        valid       = (count_q != '0);
        pop         = valid && ready;
        full        = (count_q == CW'(FIFO_DEPTH));
        wrEn        = commit && good && (!full || pop);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state. A glitch is rejected at the start-bit majority, and the
    // last stop bit releases the FSM at mid-bit so back-to-back frames work.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fall) state_d = ST_START;
            ST_START: begin
                if (midTick && majority) state_d = ST_IDLE;
                else if (bitEnd)         state_d = ST_DATA;
            end
            ST_DATA:  if (bitEnd && (bitCnt_q == BW'(DATA_WIDTH - 1)))
                          state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            ST_PAR:   if (bitEnd) state_d = ST_STOP;
            ST_STOP:  if (midTick && lastStop) state_d = isBreak ? ST_BREAK : ST_IDLE;
            ST_BREAK: if (rxSync_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Synchroniser, divider restarted on the start edge, bit sampling and
    // error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q    <= 1'b1;
            rxSync_q    <= 1'b1;
            rxPrev_q    <= 1'b1;
            divCnt_q    <= '0;
            tickCnt_q   <= '0;
            bitCnt_q    <= '0;
            stopCnt_q   <= 1'b0;
            smp0_q      <= 1'b1;
            smp1_q      <= 1'b1;
            shift_q     <= '0;
            parBit_q    <= 1'b0;
            stopLow_q   <= 1'b0;
            stopHigh_q  <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
            if (startEdge || tick) divCnt_q <= '0;
            else                   divCnt_q <= divCnt_q + DIVW'(1);
            if (startEdge)
                tickCnt_q <= '0;
            else if (tick)
                tickCnt_q <= (tickCnt_q == TW'(OVERSAMPLE - 1)) ? '0 : tickCnt_q + TW'(1);
            if (tick && (tickCnt_q == TW'(OVERSAMPLE / 2 - 1))) smp0_q <= rxSync_q;
            if (tick && (tickCnt_q == TW'(OVERSAMPLE / 2)))     smp1_q <= rxSync_q;
            if (startEdge) begin
                bitCnt_q   <= '0;
                stopCnt_q  <= 1'b0;
                stopLow_q  <= 1'b0;
                stopHigh_q <= 1'b0;
            end else begin
                if ((state_q == ST_DATA) && bitEnd) bitCnt_q <= bitCnt_q + BW'(1);
                if ((state_q == ST_STOP) && bitEnd) stopCnt_q <= 1'b1;
                if ((state_q == ST_STOP) && midTick) begin
                    stopLow_q  <= stopLow_q | ~majority;
                    stopHigh_q <= stopHigh_q | majority;
                end
            end
            if ((state_q == ST_DATA) && midTick) shift_q <= {majority, shift_q[DATA_WIDTH-1:1]};
            if ((state_q == ST_PAR) && midTick)  parBit_q <= majority;
            parityErr_q <= commit && parBad;
            frameErr_q  <= commit && frmBad;
            overrun_q   <= commit && good && full && !pop;
        end
    end

    // FIFO pointers and occupancy; a full FIFO still accepts a write when the
    // head is popped in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (wrEn) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
            count_q <= count_q + CW'(wrEn) - CW'(pop);
        end
    end

    // FIFO storage needs no reset; data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wrEn) mem_q[wrPtr_q] <= shift_q;
    end

    assign data       = valid ? mem_q[rdPtr_q] : '0;
    assign count      = count_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign overrun    = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int FRAME_BITS     = 1 + DATA_WIDTH + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int TIMEOUT_CYCLES = TIMEOUT_CHARS * FRAME_BITS * OVERSAMPLE * DIV;
    localparam int IW             = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idleCnt_q;
    logic          timeout_q;

    // Idle counter runs only while IDLE with unread data; it sticks at the
    // limit and clears on a start edge or a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idleCnt_q <= '0;
            timeout_q <= 1'b0;
        end else if (startEdge || pop) begin
            idleCnt_q <= '0;
            timeout_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && valid && !timeout_q) begin
            idleCnt_q <= idleCnt_q + IW'(1);
            if (idleCnt_q == IW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered
// Scoreboard bench for uart_rx_buffered. Two instances share the clock and
// reset: u_dut0 (no parity) and u_dut1 (even parity), both 8N-x with a 4-deep
// FIFO at 160 clk per bit. Frames are driven bit by bit; the reference model
// is a queue per instance plus expected error-pulse counts. Monitors pop the
// queues on every DUT handshake and count error pulses.
`timescale 1ns/1ps

module tb_uart_rx_buffered;

    localparam int CLK_RATE = 1_536_000;
    localparam int BAUD     = 9600;
    localparam int DEPTH    = 4;
    localparam int BIT      = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1, ready0 = 1'b0, ready1 = 1'b0;
    logic [7:0] data0, data1;
    logic [2:0] count0, count1;
    logic       valid0, valid1, busy0, busy1;
    logic       parErr0, parErr1, frmErr0, frmErr1, ovr0, ovr1, tmo0, tmo1;

    int testsRun = 0;
    int testsFailed = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int expPar[2], expFrm[2], expOvr[2];
    int obsPar[2], obsFrm[2], obsOvr[2];

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .DATA_WIDTH(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .TIMEOUT_CHARS(4)
    ) u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
        .count(count0), .busy(busy0), .parity_err(parErr0), .frame_err(frmErr0),
        .overrun(ovr0), .timeout(tmo0)
    );

    uart_rx_buffered #(
        .CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .DATA_WIDTH(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .TIMEOUT_CHARS(4)
    ) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
        .count(count1), .busy(busy1), .parity_err(parErr1), .frame_err(frmErr1),
        .overrun(ovr1), .timeout(tmo1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor for instance 0: every handshake must match the model head.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (valid0 && ready0) begin
                if (q0.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL pop0: DUT popped 0x%0h, model FIFO empty", data0);
                end else begin
                    checkOutput("pop0 data", {24'd0, data0}, {24'd0, q0.pop_front()});
                end
            end
            if (parErr0) obsPar[0]++;
            if (frmErr0) obsFrm[0]++;
            if (ovr0)    obsOvr[0]++;
        end
    end

    // Monitor for instance 1.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (valid1 && ready1) begin
                if (q1.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL pop1: DUT popped 0x%0h, model FIFO empty", data1);
                end else begin
                    checkOutput("pop1 data", {24'd0, data1}, {24'd0, q1.pop_front()});
                end
            end
            if (parErr1) obsPar[1]++;
            if (frmErr1) obsFrm[1]++;
            if (ovr1)    obsOvr[1]++;
        end
    end

    task automatic driveRx(input int which, input logic v, input int cycles);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (cycles) @(negedge clk);
    endtask

    // One complete frame; instance 1 gets an even-parity bit, inverted when
    // badPar is set. The model then records the outcome of the frame.
    task automatic applyStimulus(input int which, input logic [7:0] d, input logic badPar);
        driveRx(which, 1'b0, BIT);
        for (int i = 0; i < 8; i++) driveRx(which, d[i], BIT);
        if (which == 1) driveRx(which, (^d) ^ badPar, BIT);
        driveRx(which, 1'b1, BIT);
        if (which == 0) begin
            if (q0.size() < DEPTH) q0.push_back(d);
            else                   expOvr[0]++;
        end else if (badPar) begin
            expPar[1]++;
        end else begin
            if (q1.size() < DEPTH) q1.push_back(d);
            else                   expOvr[1]++;
        end
    endtask

    task automatic popOne(input int which);
        if (which == 0) ready0 = 1'b1;
        else            ready1 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        ready1 = 1'b0;
    endtask

    task automatic drain(input int which, input int cycles);
        repeat (cycles) begin
            if (which == 0) ready0 = 1'($urandom_range(0, 1));
            else            ready1 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ready0 = 1'b0;
        ready1 = 1'b0;
    endtask

    task automatic checkFifo(input int which, input string tag);
        int         n;
        logic [7:0] head;
        n    = (which == 0) ? q0.size() : q1.size();
        head = (n == 0) ? 8'd0 : ((which == 0) ? q0[0] : q1[0]);
        checkOutput({tag, " count"}, (which == 0) ? 32'(count0) : 32'(count1), n);
        checkOutput({tag, " valid"}, (which == 0) ? 32'(valid0) : 32'(valid1), 32'(n != 0));
        checkOutput({tag, " head"},  (which == 0) ? 32'(data0) : 32'(data1), 32'(head));
        checkOutput({tag, " parity_err pulses"}, obsPar[which], expPar[which]);
        checkOutput({tag, " frame_err pulses"},  obsFrm[which], expFrm[which]);
        checkOutput({tag, " overrun pulses"},    obsOvr[which], expOvr[which]);
    endtask

    initial begin
        logic [7:0] d;
        for (int i = 0; i < 2; i++) begin
            expPar[i] = 0; expFrm[i] = 0; expOvr[i] = 0;
            obsPar[i] = 0; obsFrm[i] = 0; obsOvr[i] = 0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset count0", 32'(count0), 0);
        checkOutput("reset valid0", 32'(valid0), 0);
        checkOutput("reset busy0",  32'(busy0), 0);
        checkOutput("reset data0",  32'(data0), 0);
        checkOutput("reset flags0", 32'({parErr0, frmErr0, ovr0, tmo0}), 0);
        checkOutput("reset flags1", 32'({parErr1, frmErr1, ovr1, tmo1, busy1, valid1}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Two frames stored, then read back in order.
        applyStimulus(0, 8'h55, 1'b0);
        checkFifo(0, "t1 first");
        applyStimulus(0, 8'hA3, 1'b0);
        checkFifo(0, "t1 second");
        popOne(0);
        popOne(0);
        checkFifo(0, "t1 drained");

        // 40-clk glitch: busy briefly, nothing stored, no flags.
        rx0 = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t2 busy in glitch", 32'(busy0), 1);
        repeat (20) @(negedge clk);
        rx0 = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("t2 busy after glitch", 32'(busy0), 0);
        checkFifo(0, "t2");

        // Even parity: good then bad 0x07, then random parity frames.
        applyStimulus(1, 8'h07, 1'b0);
        applyStimulus(1, 8'h07, 1'b1);
        checkFifo(1, "t3 fixed");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'($urandom), 1'($urandom_range(0, 1)));
            checkFifo(1, "t3 random");
        end
        drain(1, 30);
        popOne(1); popOne(1); popOne(1); popOne(1);
        checkFifo(1, "t3 drained");

        // Break: two frame times low; one frame_err, busy held until rx rises.
        driveRx(0, 1'b0, 20 * BIT);
        expFrm[0]++;
        checkOutput("t4 busy in break", 32'(busy0), 1);
        checkFifo(0, "t4 break");
        driveRx(0, 1'b1, 20);
        checkOutput("t4 busy after break", 32'(busy0), 0);
        applyStimulus(0, 8'h3C, 1'b0);
        checkFifo(0, "t4 after");
        popOne(0);

        // Overrun on the 5th frame, then a pop on the commit cycle of the 6th.
        for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 1'b0);
        checkFifo(0, "t5 full");
        // Commit cycle: 2 synchroniser flops + edge register, then the
        // last-stop middle sample is tick 9*16+9 after the edge, DIV=10 clk each.
        fork
            applyStimulus(0, 8'h06, 1'b0);
            begin
                repeat (1542) @(posedge clk);
                @(negedge clk);
                ready0 = 1'b1;
                @(negedge clk);
                ready0 = 1'b0;
            end
        join
        checkFifo(0, "t5 pop on commit");
        drain(0, 40);
        popOne(0); popOne(0); popOne(0); popOne(0);
        checkFifo(0, "t5 drained");

        // Random frames with random consumer activity between them.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) drain(0, $urandom_range(1, 8));
            checkFifo(0, "random");
        end
        popOne(0); popOne(0); popOne(0); popOne(0);
        checkFifo(0, "random drained");

        // Reset in the middle of 0x99 with two words stored.
        applyStimulus(0, 8'($urandom), 1'b0);
        applyStimulus(0, 8'($urandom), 1'b0);
        checkFifo(0, "t6 before reset");
        d = 8'h99;
        driveRx(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) driveRx(0, d[i], BIT);
        driveRx(0, d[4], 80);
        rst = 1'b1;
        #1;
        checkOutput("t6 count in reset", 32'(count0), 0);
        checkOutput("t6 valid in reset", 32'(valid0), 0);
        checkOutput("t6 busy in reset",  32'(busy0), 0);
        q0.delete();
        @(negedge clk);
        rx0 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        applyStimulus(0, 8'h42, 1'b0);
        checkFifo(0, "t6 after reset");
`ifdef UART_RX_TIMEOUT_EN
        // IDLE is entered mid stop bit, about 80 clk before the frame task ends.
        repeat (6200) @(negedge clk);
        checkOutput("timeout early", 32'(tmo0), 0);
        repeat (300) @(negedge clk);
        checkOutput("timeout raised", 32'(tmo0), 1);
        popOne(0);
        @(negedge clk);
        checkOutput("timeout cleared", 32'(tmo0), 0);
`else
        repeat (100) @(negedge clk);
        checkOutput("timeout tied low", 32'(tmo0), 0);
        popOne(0);
`endif
        checkFifo(0, "final");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
